// File: rtl/systolic_pkg.sv
// Shared types for the systolic tile sequencer: FSM states and the tile completion codes.
package systolic_pkg;

  localparam int TILE_ERR_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    STREAM,
    DRAIN,
    DONE
  } ctrl_state_e;

  typedef enum logic [TILE_ERR_W-1:0] {
    ERR_NONE      = 2'd0,
    ERR_ZERO_K    = 2'd1,
    ERR_DRAIN_TMO = 2'd2
  } tile_err_e;

endpackage

// File: rtl/systolic_tile_ctrl.sv
// Sequencer for one systolic_array tile pass: fetches A columns / B rows, streams them
// into the array, waits for the array to drain and reports the result.
module systolic_tile_ctrl
  import systolic_pkg::*;
#(
  parameter int ROWS      = 64,
  parameter int COLS      = 64,
  parameter int IP_WIDTH  = 8,
  parameter int K_W       = 16,
  parameter int DRAIN_TMO = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [K_W-1:0]             k_len,
  output logic                       busy,
  output logic                       tile_done,
  output logic [TILE_ERR_W-1:0]      tile_err,
  output logic [31:0]                tile_cycles,
  output logic                       a_rd_en,
  output logic [K_W-1:0]             a_rd_addr,
  input  logic [ROWS*IP_WIDTH-1:0]   a_rd_data,
  output logic                       b_rd_en,
  output logic [K_W-1:0]             b_rd_addr,
  input  logic [COLS*IP_WIDTH-1:0]   b_rd_data,
  output logic                       arr_en,
  output logic                       arr_clr,
  output logic [ROWS*IP_WIDTH-1:0]   arr_input,
  output logic [COLS*IP_WIDTH-1:0]   arr_weight,
  input  logic                       arr_done,
  input  logic [31:0]                arr_cycles
);

  localparam int TMO_W = $clog2(DRAIN_TMO + 1);

  ctrl_state_e      state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [K_W-1:0]   k_len_q, k_len_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  tile_err_e        err_q, err_d;
  logic [31:0]      cycles_q, cycles_d;
  logic             done_prev_q;
  logic             arr_en_q, arr_clr_q;

  // One extra bit so k_len = 2**K_W-1 compares without wrapping.
  logic [K_W:0]     k_next;
  logic             more_beats;
  logic             done_edge;

  assign k_next     = {1'b0, k_q} + {{K_W{1'b0}}, 1'b1};
  assign more_beats = k_next < {1'b0, k_len_q};
  assign done_edge  = arr_done & ~done_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      k_len_q     <= '0;
      tmo_q       <= '0;
      err_q       <= ERR_NONE;
      cycles_q    <= '0;
      done_prev_q <= 1'b0;
      arr_en_q    <= 1'b0;
      arr_clr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      k_len_q     <= k_len_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      cycles_q    <= cycles_d;
      done_prev_q <= arr_done;
      arr_en_q    <= (state_d == STREAM);
      arr_clr_q   <= (state_d == STREAM) && (k_d == '0);
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    k_len_d  = k_len_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    cycles_d = cycles_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_len_d = k_len;
          k_d     = '0;
          if (k_len == '0) begin
            state_d  = DONE;
            err_d    = ERR_ZERO_K;
            cycles_d = '0;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        state_d = STREAM;
        k_d     = '0;
      end
      STREAM: begin
        if (more_beats) begin
          k_d = k_next[K_W-1:0];
        end else begin
          state_d = DRAIN;
          tmo_d   = '0;
        end
      end
      DRAIN: begin
        // Only a fresh rising edge counts; a level left over from an earlier pass does not.
        if (done_edge) begin
          state_d  = DONE;
          err_d    = ERR_NONE;
          cycles_d = arr_cycles;
        end else if (tmo_q == TMO_W'(DRAIN_TMO - 1)) begin
          state_d  = DONE;
          err_d    = ERR_DRAIN_TMO;
          cycles_d = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign tile_done   = (state_q == DONE);
  assign tile_err    = (state_q == DONE) ? err_q : ERR_NONE;
  assign tile_cycles = cycles_q;

  // Reads run one beat ahead of the array so data lands exactly on its beat.
  assign a_rd_en   = (state_q == FETCH) || ((state_q == STREAM) && more_beats);
  assign a_rd_addr = ((state_q == STREAM) && more_beats) ? k_next[K_W-1:0] : '0;
  assign b_rd_en   = a_rd_en;
  assign b_rd_addr = a_rd_addr;

  assign arr_en     = arr_en_q;
  assign arr_clr    = arr_clr_q;
  assign arr_input  = (state_q == STREAM) ? a_rd_data : '0;
  assign arr_weight = (state_q == STREAM) ? b_rd_data : '0;

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Directed bench for systolic_tile_ctrl with behavioural operand buffers and array stub.
module tb_systolic_tile_ctrl;
  import systolic_pkg::*;

  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int IP_WIDTH  = 8;
  localparam int K_W       = 4;
  localparam int DRAIN_TMO = 16;
  localparam int FLUSH     = ROWS + COLS - 1;
  localparam int CW        = ROWS * COLS * 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [K_W-1:0]           k_len;
  logic                     busy;
  logic                     tile_done;
  logic [TILE_ERR_W-1:0]    tile_err;
  logic [31:0]              tile_cycles;
  logic                     a_rd_en;
  logic [K_W-1:0]           a_rd_addr;
  logic [ROWS*IP_WIDTH-1:0] a_rd_data = '0;
  logic                     b_rd_en;
  logic [K_W-1:0]           b_rd_addr;
  logic [COLS*IP_WIDTH-1:0] b_rd_data = '0;
  logic                     arr_en;
  logic                     arr_clr;
  logic [ROWS*IP_WIDTH-1:0] arr_input;
  logic [COLS*IP_WIDTH-1:0] arr_weight;
  logic                     arr_done = 1'b0;
  logic [31:0]              arr_cycles = '0;

  int tests = 0;
  int fails = 0;

  systolic_tile_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .IP_WIDTH(IP_WIDTH), .K_W(K_W), .DRAIN_TMO(DRAIN_TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .busy(busy), .tile_done(tile_done), .tile_err(tile_err), .tile_cycles(tile_cycles),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .arr_en(arr_en), .arr_clr(arr_clr), .arr_input(arr_input), .arr_weight(arr_weight),
    .arr_done(arr_done), .arr_cycles(arr_cycles)
  );

  always #5 clk = ~clk;

  // Operand buffers with one cycle read latency.
  logic [ROWS*IP_WIDTH-1:0] a_mem [16];
  logic [COLS*IP_WIDTH-1:0] b_mem [16];

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
    if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
  end

  // Array stub: outer-product accumulate, counts en-high cycles, raises done FLUSH cycles after en drops.
  logic [31:0] acc [ROWS][COLS];
  logic        en_prev_m = 1'b0;
  int          flush_cnt = 0;
  bit          stub_done_low = 1'b0;

  always @(posedge clk) begin
    en_prev_m <= arr_en;
    if (arr_en) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          acc[i][j] <= (arr_clr ? 32'd0 : acc[i][j]) +
                       32'(arr_input[i*IP_WIDTH +: IP_WIDTH]) * 32'(arr_weight[j*IP_WIDTH +: IP_WIDTH]);
      if (!en_prev_m) begin
        arr_cycles <= 32'd1;
        arr_done   <= 1'b0;
      end else begin
        arr_cycles <= arr_cycles + 32'd1;
      end
      flush_cnt <= 0;
    end else if (en_prev_m) begin
      flush_cnt <= FLUSH;
    end else if (flush_cnt != 0) begin
      flush_cnt <= flush_cnt - 1;
      if (flush_cnt == 1 && !stub_done_low) arr_done <= 1'b1;
    end
  end

  // Running protocol counters, sampled away from the active edge.
  int   en_total = 0, clr_total = 0, clr_bad = 0, done_total = 0, done_long = 0, rd_mismatch = 0;
  int   gap = 0, min_gap = 1000;
  bit   seen_pass = 1'b0;
  logic prev_en_n = 1'b0, prev_done_n = 1'b0;

  always @(negedge clk) begin
    if (arr_en) en_total++;
    if (arr_en && arr_clr) clr_total++;
    if (arr_clr && (!arr_en || prev_en_n)) clr_bad++;
    if (tile_done) done_total++;
    if (tile_done && prev_done_n) done_long++;
    if (a_rd_en !== b_rd_en || a_rd_addr !== b_rd_addr) rd_mismatch++;
    if (arr_en && !prev_en_n) begin
      if (seen_pass && gap < min_gap) min_gap = gap;
      seen_pass = 1'b1;
    end
    gap = arr_en ? 0 : gap + 1;
    prev_en_n   = arr_en;
    prev_done_n = tile_done;
  end

  typedef struct packed {
    logic          chk_c;
    logic [1:0]    err;
    logic [31:0]   cyc;
    logic [CW-1:0] c;
  } exp_t;

  exp_t sb[$];

  function automatic logic [CW-1:0] modelC(input int k);
    logic [CW-1:0] res;
    logic [31:0]   sum;
    res = '0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) begin
        sum = 0;
        for (int kk = 0; kk < k; kk++)
          sum += 32'(a_mem[kk][i*IP_WIDTH +: IP_WIDTH]) * 32'(b_mem[kk][j*IP_WIDTH +: IP_WIDTH]);
        res[(i*COLS+j)*32 +: 32] = sum;
      end
    return res;
  endfunction

  function automatic void pushExpect(input logic chk, input logic [1:0] err,
                                     input logic [31:0] cyc, input int k);
    exp_t e;
    e.chk_c = chk;
    e.err   = err;
    e.cyc   = cyc;
    e.c     = modelC(k);
    sb.push_back(e);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [K_W-1:0] k, input bit hold);
    k_len = k;
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
  endtask

  task automatic waitTileDone(input int budget, output int cyc);
    cyc = 1;
    while (tile_done !== 1'b1 && cyc < budget) begin
      step();
      cyc++;
    end
    checkOutput("tile_done_seen", 32'(tile_done), 32'd1);
  endtask

  task automatic checkDone(input string tag);
    exp_t e;
    tests++;
    assert (sb.size() > 0)
    else begin
      fails++;
      $error("[TB] FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({tag, "_err"}, 32'(tile_err), 32'(e.err));
      checkOutput({tag, "_cycles"}, tile_cycles, e.cyc);
      if (e.chk_c)
        for (int i = 0; i < ROWS; i++)
          for (int j = 0; j < COLS; j++)
            checkOutput($sformatf("%s_C%0d%0d", tag, i, j), acc[i][j], e.c[(i*COLS+j)*32 +: 32]);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_tile_done"}, 32'(tile_done), 32'd0);
    checkOutput({tag, "_tile_err"}, 32'(tile_err), 32'd0);
    checkOutput({tag, "_tile_cycles"}, tile_cycles, 32'd0);
    checkOutput({tag, "_rd_en"}, 32'({a_rd_en, b_rd_en}), 32'd0);
    checkOutput({tag, "_rd_addr"}, 32'({a_rd_addr, b_rd_addr}), 32'd0);
    checkOutput({tag, "_arr_en_clr"}, 32'({arr_en, arr_clr}), 32'd0);
    checkOutput({tag, "_arr_input"}, 32'(arr_input), 32'd0);
    checkOutput({tag, "_arr_weight"}, 32'(arr_weight), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc, en0, clr0, d0;
    rst   = 1'b1;
    start = 1'b0;
    k_len = '0;
    for (int k = 0; k < 16; k++) begin
      a_mem[k] = '0;
      b_mem[k] = '0;
      if (k < ROWS) a_mem[k][k*IP_WIDTH +: IP_WIDTH] = 8'd1;
      if (k < COLS) b_mem[k][k*IP_WIDTH +: IP_WIDTH] = 8'd1;
    end
    repeat (2) step();
    checkResetOutputs("reset");
    rst = 1'b0;
    step();

    // Identity x identity, k_len=4.
    en0 = en_total; clr0 = clr_total;
    pushExpect(1'b1, ERR_NONE, 32'd4, 4);
    applyStimulus(4'd4, 1'b0);
    checkOutput("fetch_rd_en", 32'(a_rd_en), 32'd1);
    checkOutput("fetch_rd_addr", 32'(a_rd_addr), 32'd0);
    checkOutput("fetch_arr_en", 32'(arr_en), 32'd0);
    checkOutput("fetch_busy", 32'(busy), 32'd1);
    step();
    checkOutput("beat0_en_clr", 32'({arr_en, arr_clr}), 32'd3);
    checkOutput("beat0_rd_addr", 32'(a_rd_addr), 32'd1);
    checkOutput("beat0_input", 32'(arr_input), 32'(a_mem[0]));
    checkOutput("beat0_weight", 32'(arr_weight), 32'(b_mem[0]));
    waitTileDone(64, cyc);
    checkDone("ident");
    checkOutput("ident_beats", en_total - en0, 32'd4);
    checkOutput("ident_clr", clr_total - clr0, 32'd1);

    // k_len=0 finishes straight away with an error and never touches the array.
    step();
    en0 = en_total;
    pushExpect(1'b0, ERR_ZERO_K, 32'd0, 0);
    applyStimulus(4'd0, 1'b0);
    waitTileDone(4, cyc);
    checkOutput("k0_latency", cyc, 32'd1);
    checkDone("k0");
    step();
    checkOutput("k0_no_en", en_total - en0, 32'd0);
    checkOutput("k0_idle", 32'(busy), 32'd0);

    for (int k = 0; k < 16; k++) begin
      a_mem[k] = ROWS*IP_WIDTH'($urandom);
      b_mem[k] = COLS*IP_WIDTH'($urandom);
    end

    // Back-to-back passes with start held high.
    en0 = en_total; clr0 = clr_total;
    pushExpect(1'b1, ERR_NONE, 32'd3, 3);
    applyStimulus(4'd3, 1'b1);
    waitTileDone(64, cyc);
    checkDone("b2b_first");
    k_len = 4'd5;
    pushExpect(1'b1, ERR_NONE, 32'd5, 5);
    repeat (2) step();
    start = 1'b0;
    checkOutput("b2b_refetch", 32'(a_rd_en), 32'd1);
    waitTileDone(64, cyc);
    checkDone("b2b_second");
    checkOutput("b2b_beats", en_total - en0, 32'd8);
    checkOutput("b2b_clr", clr_total - clr0, 32'd2);
    checkOutput("b2b_gap_ge2", 32'(min_gap >= 2), 32'd1);

    // Start pulses during STREAM and DRAIN must be ignored.
    step();
    d0 = done_total;
    pushExpect(1'b1, ERR_NONE, 32'd6, 6);
    applyStimulus(4'd6, 1'b0);
    repeat (2) step();
    k_len = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    checkOutput("ign_in_drain", 32'({busy, arr_en}), 32'd2);
    k_len = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    waitTileDone(64, cyc);
    checkDone("ignore");
    repeat (10) step();
    checkOutput("ign_one_done", done_total - d0, 32'd1);
    checkOutput("ign_idle", 32'(busy), 32'd0);

    // Reset on beat 2 of an 8-deep pass aborts it silently.
    d0 = done_total;
    applyStimulus(4'd8, 1'b0);
    repeat (3) step();
    checkOutput("abort_beat2", 32'({arr_en, arr_clr}), 32'd2);
    rst = 1'b1;
    step();
    checkResetOutputs("abort");
    rst = 1'b0;
    repeat (12) step();
    checkOutput("abort_no_done", done_total - d0, 32'd0);
    pushExpect(1'b1, ERR_NONE, 32'd8, 8);
    applyStimulus(4'd8, 1'b0);
    waitTileDone(64, cyc);
    checkDone("after_abort");

    // Array never signals done: drain timeout.
    step();
    stub_done_low = 1'b1;
    pushExpect(1'b1, ERR_DRAIN_TMO, 32'd0, 2);
    applyStimulus(4'd2, 1'b0);
    waitTileDone(64, cyc);
    checkOutput("tmo_latency", cyc, 32'(2 + 2 + DRAIN_TMO));
    checkDone("timeout");
    stub_done_low = 1'b0;

    // Deepest k_len streams every beat without the counter wrapping.
    step();
    en0 = en_total;
    pushExpect(1'b1, ERR_NONE, 32'd15, 15);
    applyStimulus(4'd15, 1'b0);
    waitTileDone(128, cyc);
    checkDone("kmax");
    checkOutput("kmax_beats", en_total - en0, 32'd15);

    checkOutput("clr_only_beat0", clr_bad, 32'd0);
    checkOutput("done_one_cycle", done_long, 32'd0);
    checkOutput("rd_a_eq_b", rd_mismatch, 32'd0);
    checkOutput("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
